core_sequencer: RTL

Multi-cycle control FSM that steps one instruction at a time through the fetch, decode, exec, mem and writeback units of the core via their `enabled`/`completed` handshakes. It skips mem and writeback when the decoded instruction needs neither. It redirects to the trap unit on exceptions or pending interrupts, and reports retirement. It sits in the core top, above the decoder and its sibling stage units.

---
 rtl/core_sequencer_pkg.sv | 30 +++
 rtl/core_seq_counters.sv | 33 +++
 rtl/core_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/core_sequencer_pkg.sv
// core_sequencer_pkg
//   Shared definitions for the instruction sequencer: the FSM state encoding
//   (also consumed by debug/CSR logic) and the instruction-boundary decision.
//   Optional feature macro used by this slice: CORE_SEQ_PERF_EN.
package core_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } seq_state_t;

  // Where the sequencer goes between instructions: stopping wins over an
  // interrupt, an interrupt wins over fetching the next instruction.
  function automatic seq_state_t boundary_state(input logic run,
                                                input logic irq_pending);
    if (!run) begin
      return S_IDLE;
    end
    if (irq_pending) begin
      return S_TRAP;
    end
    return S_FETCH;
  endfunction

endpackage

// File: rtl/core_seq_counters.sv
// core_seq_counters
//   Free-running performance counters for the sequencer. Only present when
//   the build defines CORE_SEQ_PERF_EN; otherwise this file is empty.
//   Ports:
//     clk           in  1   core clock
//     rst           in  1   synchronous active-high reset, clears both counters
//     retire_pulse  in  1   one-cycle pulse per retired instruction
//     cycle_count   out 64  cycles elapsed since reset was released
//     instret_count out 64  instructions retired since reset was released
`ifdef CORE_SEQ_PERF_EN
module core_seq_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        retire_pulse,
  output logic [63:0] cycle_count,
  output logic [63:0] instret_count
);

  // Both counters wrap naturally at 2^64.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count   <= 64'd0;
      instret_count <= 64'd0;
    end else begin
      cycle_count <= cycle_count + 64'd1;
      if (retire_pulse) begin
        instret_count <= instret_count + 64'd1;
      end
    end
  end

endmodule
`endif

// File: rtl/core_sequencer.sv
// core_sequencer
//   Multi-cycle control FSM that walks one instruction at a time through the
//   fetch, decode, exec, mem and writeback units using en/done handshakes,
//   skips mem/writeback when the decoded instruction needs neither, diverts
//   to the trap unit on exceptions or pending interrupts, and flags
//   retirement.
//   Optional feature macro: CORE_SEQ_PERF_EN adds cycle/instret counters.
//   Ports:
//     clk, rst                 core clock, synchronous active-high reset
//     run                      allow a new instruction (boundary only)
//     fetch_en .. trap_en      one-cycle start pulses to the stage units
//     fetch_done .. trap_done  stage completion
//     is_load, is_store, rv32a, writes_to_reg
//                              decoded flags, latched on decode completion
//     exec_trap, mem_trap      exceptions qualified by exec_done / mem_done
//     irq_pending              enabled interrupt pending (boundary only)
//     busy                     high whenever the FSM is not idle
//     instr_retired            pulse in the cycle the final done is accepted
//     state                    current FSM state for debug
//     cycle_count, instret_count (CORE_SEQ_PERF_EN only) 64-bit counters
module core_sequencer
  import core_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  output logic       fetch_en,
  output logic       decode_en,
  output logic       exec_en,
  output logic       mem_en,
  output logic       wb_en,
  output logic       trap_en,
  input  logic       fetch_done,
  input  logic       decode_done,
  input  logic       exec_done,
  input  logic       mem_done,
  input  logic       wb_done,
  input  logic       trap_done,
  input  logic       is_load,
  input  logic       is_store,
  input  logic       rv32a,
  input  logic       writes_to_reg,
  input  logic       exec_trap,
  input  logic       mem_trap,
  input  logic       irq_pending,
  output logic       busy,
  output logic       instr_retired,
  output logic [2:0] state
`ifdef CORE_SEQ_PERF_EN
  ,
  output logic [63:0] cycle_count,
  output logic [63:0] instret_count
`endif
);

  seq_state_t state_q;
  seq_state_t state_d;
  seq_state_t boundary_st;
  logic       advance;
  logic       retire;

  logic load_q;
  logic store_q;
  logic amo_q;
  logic wreg_q;

  // A stage's done is only accepted once its start pulse has dropped, so a
  // done coinciding with the entry cycle is ignored; dones from any stage
  // other than the current one are never looked at.
  always_comb begin
    boundary_st = boundary_state(run, irq_pending);
    state_d     = state_q;
    advance     = 1'b0;
    retire      = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = boundary_st;
        advance = 1'b1;
      end
      S_FETCH: begin
        if (fetch_done && !fetch_en) begin
          state_d = S_DECODE;
          advance = 1'b1;
        end
      end
      S_DECODE: begin
        if (decode_done && !decode_en) begin
          state_d = S_EXEC;
          advance = 1'b1;
        end
      end
      S_EXEC: begin
        if (exec_done && !exec_en) begin
          advance = 1'b1;
          if (exec_trap) begin
            state_d = S_TRAP;
          end else if (load_q || store_q || amo_q) begin
            state_d = S_MEM;
          end else if (wreg_q) begin
            state_d = S_WB;
          end else begin
            state_d = boundary_st;
            retire  = 1'b1;
          end
        end
      end
      S_MEM: begin
        if (mem_done && !mem_en) begin
          advance = 1'b1;
          if (mem_trap) begin
            state_d = S_TRAP;
          end else if (wreg_q) begin
            state_d = S_WB;
          end else begin
            state_d = boundary_st;
            retire  = 1'b1;
          end
        end
      end
      S_WB: begin
        if (wb_done && !wb_en) begin
          state_d = boundary_st;
          advance = 1'b1;
          retire  = 1'b1;
        end
      end
      S_TRAP: begin
        if (trap_done && !trap_en) begin
          state_d = boundary_st;
          advance = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        advance = 1'b1;
      end
    endcase
  end

  // Start pulses fire on every entry into a stage, including TRAP -> TRAP
  // when an interrupt is still pending after the trap handler completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      fetch_en  <= 1'b0;
      decode_en <= 1'b0;
      exec_en   <= 1'b0;
      mem_en    <= 1'b0;
      wb_en     <= 1'b0;
      trap_en   <= 1'b0;
      load_q    <= 1'b0;
      store_q   <= 1'b0;
      amo_q     <= 1'b0;
      wreg_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      fetch_en  <= advance && (state_d == S_FETCH);
      decode_en <= advance && (state_d == S_DECODE);
      exec_en   <= advance && (state_d == S_EXEC);
      mem_en    <= advance && (state_d == S_MEM);
      wb_en     <= advance && (state_d == S_WB);
      trap_en   <= advance && (state_d == S_TRAP);
      if (state_q == S_DECODE && decode_done && !decode_en) begin
        load_q  <= is_load;
        store_q <= is_store;
        amo_q   <= rv32a;
        wreg_q  <= writes_to_reg;
      end
    end
  end

  assign busy          = (state_q != S_IDLE);
  // Reset in the same cycle as the final done suppresses the retirement.
  assign instr_retired = retire && !rst;
  assign state         = state_q;

`ifdef CORE_SEQ_PERF_EN
  core_seq_counters u_counters (
    .clk           (clk),
    .rst           (rst),
    .retire_pulse  (instr_retired),
    .cycle_count   (cycle_count),
    .instret_count (instret_count)
  );
`endif

endmodule
